// File: rtl/sipo.sv
// rtl/sipo.sv - 70-bit serial-in parallel-out word assembler with 14-entry row index
module sipo (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        din,
  output logic        load,
  output logic [69:0] dout,
  output logic [3:0]  row
);

  localparam int unsigned WORD_W   = 70;
  localparam int unsigned ROWS     = 14;
  localparam logic [6:0]  LAST_BIT = 7'(WORD_W - 1);
  localparam logic [3:0]  LAST_ROW = 4'(ROWS - 1);

  logic [69:0] shift_q;
  logic [6:0]  bit_cnt;
  logic [3:0]  word_idx;
  logic [69:0] next_shift;

  // The word being completed includes the bit arriving on this very edge.
  assign next_shift = {shift_q[68:0], din};

  // Shift, count accepted bits, and publish a finished word with a one-cycle load pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q  <= '0;
      bit_cnt  <= '0;
      word_idx <= '0;
      dout     <= '0;
      row      <= '0;
      load     <= 1'b0;
    end else begin
      load <= 1'b0;
      if (en) begin
        shift_q <= next_shift;
        if (bit_cnt == LAST_BIT) begin
          dout     <= next_shift;
          row      <= word_idx;
          load     <= 1'b1;
          bit_cnt  <= '0;
          word_idx <= (word_idx == LAST_ROW) ? 4'd0 : word_idx + 4'd1;
        end else begin
          bit_cnt <= bit_cnt + 7'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sipo.sv
// tb/tb_sipo.sv - randomized self-checking bench for sipo against a bit-queue reference model
module tb_sipo;

  logic        clk;
  logic        rst;
  logic        en;
  logic        din;
  logic        load;
  logic [69:0] dout;
  logic [3:0]  row;

  sipo dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .din  (din),
    .load (load),
    .dout (dout),
    .row  (row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // reference model state
  bit          q[$];
  int          words_done = 0;
  logic        exp_load = 1'b0;
  logic [69:0] exp_dout = '0;
  logic [3:0]  exp_row  = '0;
  int          cycles = 0;
  int          last_load_cycle = 0;

  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%018h expected 0x%018h", tag, got, exp);
    end
  endtask

  // one clock cycle: drive inputs, advance the model on the edge, compare just after it
  task automatic step(input logic e, input logic d);
    logic [69:0] w;
    en  = e;
    din = d;
    @(posedge clk);
    exp_load = 1'b0;
    if (!rst) begin
      q.delete();
      words_done = 0;
      exp_dout = '0;
      exp_row  = '0;
    end else if (e) begin
      q.push_back(d);
      if (q.size() == 70) begin
        for (int i = 0; i < 70; i++) w[69-i] = q[i];
        exp_dout = w;
        exp_row  = 4'(words_done % 14);
        exp_load = 1'b1;
        words_done++;
        q.delete();
      end
    end
    #1;
    cycles++;
    check("load", {69'd0, load}, {69'd0, exp_load});
    check("dout", dout, exp_dout);
    check("row",  {66'd0, row}, {66'd0, exp_row});
    if (load) last_load_cycle = cycles;
  endtask

  // send one word MSB first, optionally pausing en for gap_len cycles before bit index gap_at
  task automatic send_word(input logic [69:0] w, input int gap_at, input int gap_len);
    for (int i = 0; i < 70; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) step(1'b0, 1'($urandom));
      end
      step(1'b1, w[69-i]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load"}, {69'd0, load}, 70'd0);
    check({tag, "_dout"}, dout, 70'd0);
    check({tag, "_row"},  {66'd0, row}, 70'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs("async_rst");
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom));
    check_reset_outputs("held_rst");
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [69:0] w;
  int          start;
  int          pos;

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    din = 1'b0;
    #2 rst = 1'b0;
    #1 check_reset_outputs("init_rst");
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom));
    @(negedge clk);
    rst = 1'b1;

    // single known word
    start = cycles;
    send_word(70'h204016000000000000, -1, 0);
    check("w0_latency", 70'(last_load_cycle - start), 70'd70);
    check("w0_dout", dout, 70'h204016000000000000);

    // 14 back-to-back words from a fresh reset, then a 15th that wraps row
    do_reset();
    for (int k = 0; k < 15; k++) begin
      if (k == 0)       w = 70'h004023000000000000;
      else if (k == 12) w = 70'h00C07D46072866091F;
      else              w = {6'($urandom), $urandom, $urandom};
      start = cycles;
      send_word(w, -1, 0);
      check("b2b_spacing", 70'(last_load_cycle - start), 70'd70);
      check("b2b_dout", dout, w);
      check("b2b_row", {66'd0, row}, 70'(k % 14));
    end

    // en gap of 5 cycles mid-word
    w = {6'($urandom), $urandom, $urandom};
    start = cycles;
    send_word(w, 33, 5);
    check("gap_latency", 70'(last_load_cycle - start), 70'd75);
    check("gap_dout", dout, w);

    // reset after 30 bits of a word, then a full word
    for (int i = 0; i < 30; i++) step(1'b1, 1'($urandom));
    do_reset();
    start = cycles;
    send_word(70'h003FD06C4C5974E65C, -1, 0);
    check("postrst_latency", 70'(last_load_cycle - start), 70'd70);
    check("postrst_dout", dout, 70'h003FD06C4C5974E65C);
    check("postrst_row", {66'd0, row}, 70'd0);

    // all ones then all zeros
    send_word({70{1'b1}}, -1, 0);
    check("ones_dout", dout, 70'h3FFFFFFFFFFFFFFFFF);
    send_word(70'd0, -1, 0);
    check("zeros_dout", dout, 70'd0);

    // random en/din traffic checked cycle by cycle against the model
    for (int i = 0; i < 1200; i++) step(1'($urandom_range(0, 9) < 7), 1'($urandom));

    // random mid-stream reset
    pos = $urandom_range(1, 69);
    for (int i = 0; i < pos; i++) step(1'b1, 1'($urandom));
    do_reset();
    for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 9) < 8), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
